// File: rtl/multi_clock_divider.sv
// rtl/multi_clock_divider.sv - multi-channel programmable clock-enable divider
// Per-channel divided square wave / pulse with shadowed, glitch-free divisor updates.
module multi_clock_divider #(
  parameter int   CHANNELS     = 4,
  parameter int   CNT_WIDTH    = 25,
  parameter int   CH_W         = 2,
  parameter int   DEFAULT_DIV  = 6000000 - 1,
  parameter logic DEFAULT_MODE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [CH_W-1:0]      wr_chan,
  input  logic [CNT_WIDTH-1:0] wr_div,
  input  logic                 wr_mode,
  input  logic [CHANNELS-1:0]  ch_en,
  input  logic                 sync,
  output logic [CHANNELS-1:0]  out,
  output logic [CHANNELS-1:0]  tick
);

  localparam logic [CNT_WIDTH-1:0] DIV_INIT = CNT_WIDTH'(DEFAULT_DIV);

  logic [CNT_WIDTH-1:0] count   [CHANNELS];
  logic [CNT_WIDTH-1:0] term    [CHANNELS];
  logic [CNT_WIDTH-1:0] sh_term [CHANNELS];
  logic [CHANNELS-1:0]  mode;
  logic [CHANNELS-1:0]  sh_mode;
  logic [CHANNELS-1:0]  wrap;
  logic [CHANNELS-1:0]  commit;
  logic [CHANNELS-1:0]  wr_hit;

  // Commits only happen with count returning to 0, so count can never overshoot term.
  always_comb begin
    wrap   = '0;
    commit = '0;
    wr_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wrap[i]   = (count[i] == term[i]);
      commit[i] = sync | ~ch_en[i] | wrap[i];
      wr_hit[i] = wr_en && (wr_chan == CH_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        count[i]   <= '0;
        term[i]    <= DIV_INIT;
        sh_term[i] <= DIV_INIT;
      end
      mode    <= {CHANNELS{DEFAULT_MODE}};
      sh_mode <= {CHANNELS{DEFAULT_MODE}};
      out     <= '0;
      tick    <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sync || !ch_en[i]) begin
          count[i] <= '0;
          out[i]   <= 1'b0;
          tick[i]  <= 1'b0;
        end else if (wrap[i]) begin
          count[i] <= '0;
          tick[i]  <= 1'b1;
          out[i]   <= mode[i] ? 1'b1 : ~out[i];
        end else begin
          count[i] <= count[i] + 1'b1;
          tick[i]  <= 1'b0;
          if (mode[i])
            out[i] <= 1'b0;
        end

        // A write landing on a commit edge stays in the shadow until the next event.
        if (commit[i]) begin
          term[i] <= sh_term[i];
          mode[i] <= sh_mode[i];
        end
        if (wr_hit[i]) begin
          sh_term[i] <= wr_div;
          sh_mode[i] <= wr_mode;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// tb/tb_multi_clock_divider.sv - directed self-checking bench for multi_clock_divider
// Event-time reference model compared every cycle, plus literal expectations per scenario.
module tb_multi_clock_divider;
  localparam int NCH = 4;
  localparam int CW  = 25;
  localparam int DEF = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_chan = '0;
  logic [CW-1:0] wr_div = '0;
  logic          wr_mode = 1'b0;
  logic [NCH-1:0] ch_en = '1;
  logic          sync = 1'b0;
  logic [NCH-1:0] out;
  logic [NCH-1:0] tick;

  int checks = 0;
  int failures = 0;
  int kk = 0;
  bit mon_on = 1'b0;

  multi_clock_divider #(
    .CHANNELS(NCH), .CNT_WIDTH(CW), .CH_W(3), .DEFAULT_DIV(DEF), .DEFAULT_MODE(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_chan(wr_chan), .wr_div(wr_div),
    .wr_mode(wr_mode), .ch_en(ch_en), .sync(sync), .out(out), .tick(tick)
  );

  always #5 clk = ~clk;

  // Reference: each channel predicts the absolute edge number of its next wrap.
  int mcyc;
  int next_wrap [NCH];
  int act_t [NCH];
  int sh_t [NCH];
  bit act_m [NCH];
  bit sh_m [NCH];
  logic [NCH-1:0] e_out = '0;
  logic [NCH-1:0] e_tick = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcyc = 0;
      for (int i = 0; i < NCH; i++) begin
        act_t[i] = DEF; sh_t[i] = DEF; act_m[i] = 0; sh_m[i] = 0;
        next_wrap[i] = DEF + 1;
      end
      e_out = '0;
      e_tick = '0;
    end else begin
      mcyc++;
      for (int i = 0; i < NCH; i++) begin
        if (sync || !ch_en[i]) begin
          act_t[i] = sh_t[i]; act_m[i] = sh_m[i];
          e_out[i] = 0; e_tick[i] = 0;
          next_wrap[i] = mcyc + act_t[i] + 1;
        end else if (mcyc == next_wrap[i]) begin
          e_tick[i] = 1;
          e_out[i] = act_m[i] ? 1'b1 : ~e_out[i];
          act_t[i] = sh_t[i]; act_m[i] = sh_m[i];
          next_wrap[i] = mcyc + act_t[i] + 1;
        end else begin
          e_tick[i] = 0;
          if (act_m[i]) e_out[i] = 0;
        end
      end
      if (wr_en && int'(wr_chan) < NCH) begin
        sh_t[int'(wr_chan)] = int'(wr_div);
        sh_m[int'(wr_chan)] = wr_mode;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      checks++;
      if (tick !== e_tick) begin
        failures++;
        $display("FAIL model_tick t=%0t actual=%b required=%b", $time, tick, e_tick);
      end
      checks++;
      if (out !== e_out) begin
        failures++;
        $display("FAIL model_out t=%0t actual=%b required=%b", $time, out, e_out);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d actual=%0h required=%0h", nm, kk, act, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(negedge clk);
      kk++;
    end
  endtask

  logic [11:0] tick_pat;
  logic [11:0] out_pat;

  initial begin
    tick_pat = 12'b1000_1000_1000;
    out_pat  = 12'b1000_0111_1000;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    mon_on = 1'b1;
    chk("reset_out", 32'(out), 32'h0);
    chk("reset_tick", 32'(tick), 32'h0);
    rst = 1'b0;
    kk = 0;

    // Basic divide with T=3 on every channel
    for (int n = 0; n < 12; n++) begin
      adv(1);
      chk("basic_tick", 32'(tick), tick_pat[kk-1] ? 32'hF : 32'h0);
      chk("basic_out", 32'(out), out_pat[kk-1] ? 32'hF : 32'h0);
    end

    // Glitch-free update on channel 1: 4-cycle period completes, then 2-cycle
    adv(1);
    wr_en = 1'b1; wr_chan = 3'd1; wr_div = 1; wr_mode = 1'b0;
    adv(1);
    wr_en = 1'b0;
    for (int n = 0; n < 6; n++) begin
      adv(1);
      chk("update_tick1", 32'(tick[1]), (kk == 16 || kk == 18 || kk == 20) ? 32'h1 : 32'h0);
    end

    // T=0 pulse mode on channel 2, then sync
    wr_en = 1'b1; wr_chan = 3'd2; wr_div = 0; wr_mode = 1'b1;
    adv(1);
    wr_en = 1'b0; sync = 1'b1;
    adv(1);
    sync = 1'b0;
    chk("sync_out", 32'(out), 32'h0);
    chk("sync_tick", 32'(tick), 32'h0);
    for (int n = 0; n < 5; n++) begin
      adv(1);
      chk("t0_out2", 32'(out[2]), 32'h1);
      chk("t0_tick2", 32'(tick[2]), 32'h1);
    end

    // Sync alignment: ch0 T=4, ch3 T=9 started at different times
    wr_en = 1'b1; wr_chan = 3'd0; wr_div = 4; wr_mode = 1'b0;
    adv(1);
    wr_chan = 3'd3; wr_div = 9;
    adv(1);
    wr_en = 1'b0; ch_en[3] = 1'b0;
    adv(1);
    ch_en[3] = 1'b1;
    adv(15);
    sync = 1'b1;
    adv(1);
    sync = 1'b0;
    for (int n = 0; n < 20; n++) begin
      adv(1);
      chk("align_tick0", 32'(tick[0]), ((kk - 46) % 5 == 0) ? 32'h1 : 32'h0);
      chk("align_tick3", 32'(tick[3]), ((kk - 46) % 10 == 0) ? 32'h1 : 32'h0);
    end

    // Disable channel 0 for two cycles
    ch_en[0] = 1'b0;
    adv(1);
    chk("dis_out0", 32'(out[0]), 32'h0);
    chk("dis_tick0", 32'(tick[0]), 32'h0);
    adv(1);
    ch_en[0] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      adv(1);
      chk("reen_tick0", 32'(tick[0]), (kk == 73) ? 32'h1 : 32'h0);
    end

    // Out-of-range channel write must not touch any channel
    wr_en = 1'b1; wr_chan = 3'd4; wr_div = 0; wr_mode = 1'b1;
    adv(1);
    wr_en = 1'b0;
    adv(1);
    sync = 1'b1;
    adv(1);
    sync = 1'b0;
    adv(1);
    chk("inval_tick_77", 32'(tick), 32'h4);
    adv(1);
    chk("inval_tick_78", 32'(tick), 32'h6);
    adv(3);
    chk("inval_tick_81", 32'(tick), 32'h5);

    // Asynchronous reset mid-count
    adv(1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", 32'(out), 32'h0);
    chk("async_rst_tick", 32'(tick), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    kk = 0;
    for (int n = 0; n < 8; n++) begin
      adv(1);
      chk("post_rst_tick", 32'(tick), (kk % 4 == 0) ? 32'hF : 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
